pio_poll_master: RTL and testbench

Avalon-MM read initiator that periodically polls a 4-bit input PIO responder at address 0, debounces the returned value, and reports the stable input state with rise/fall edge masks and a one-cycle change pulse. Sits between the key/switch input PIO and the control logic that needs clean, event-style input without a soft processor in the loop.

---
 rtl/pio_poll_master.sv | 91 +++++++++
 tb/tb_pio_poll_master.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pio_poll_master.sv
// pio_poll_master: polls a 4-bit input PIO over Avalon-MM, debounces it, reports edges and change pulses
module pio_poll_master #(
    parameter int POLL_DIV     = 50000,
    parameter int DATA_WIDTH   = 4,
    parameter int STABLE_COUNT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic [1:0]            avm_address,
    output logic                  avm_read,
    input  logic [31:0]           avm_readdata,
    output logic [DATA_WIDTH-1:0] state_out,
    output logic [DATA_WIDTH-1:0] rise_mask,
    output logic [DATA_WIDTH-1:0] fall_mask,
    output logic                  change_pulse,
    output logic                  busy
);
    localparam int DIV_W = $clog2(POLL_DIV);
    localparam int CNT_W = $clog2(STABLE_COUNT + 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(POLL_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT);

    typedef enum logic [1:0] {IDLE, READ, CAPTURE, EVAL} state_t;

    state_t                  state, state_nxt;
    logic [DIV_W-1:0]        div_cnt;
    logic                    tick;
    logic [DATA_WIDTH-1:0]   sample, cand;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    commit;
    logic                    unused_hi;

    assign unused_hi   = ^avm_readdata[31:DATA_WIDTH];
    assign tick        = enable && (div_cnt == '0);
    assign avm_read    = (state == READ);
    assign avm_address = 2'd0;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = tick ? READ : IDLE;
            READ:    state_nxt = CAPTURE;
            CAPTURE: state_nxt = EVAL;
            default: state_nxt = IDLE;
        endcase
    end

    // Run length of identical samples, saturating so a held input never re-commits
    always_comb begin
        cnt_nxt = (sample != cand) ? CNT_W'(1) : (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
        commit  = (state == EVAL) && (cnt_nxt == CNT_MAX) && (sample != state_out);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt      <= DIV_LOAD;
            sample       <= '0;
            cand         <= '0;
            cnt          <= '0;
            state_out    <= '0;
            rise_mask    <= '0;
            fall_mask    <= '0;
            change_pulse <= 1'b0;
        end else begin
            div_cnt      <= (!enable || div_cnt == '0) ? DIV_LOAD : div_cnt - DIV_W'(1);
            change_pulse <= commit;
            if (state == CAPTURE) begin
                sample <= avm_readdata[DATA_WIDTH-1:0];
            end
            if (state == EVAL) begin
                cand <= sample;
                cnt  <= cnt_nxt;
            end
            if (commit) begin
                state_out <= sample;
                rise_mask <= sample & ~state_out;
                fall_mask <= ~sample & state_out;
            end
        end
    end
endmodule

// File: tb/tb_pio_poll_master.sv
// tb_pio_poll_master: directed vector bench with a registered-readdata PIO responder model
module tb_pio_poll_master;
    localparam int PD = 8;
    localparam int SC = 3;
    localparam int W  = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b1;
    logic [1:0]   avm_address;
    logic         avm_read;
    logic [31:0]  avm_readdata = '0;
    logic [W-1:0] state_out, rise_mask, fall_mask;
    logic         change_pulse, busy;
    logic [3:0]   in_port = 4'b0101;
    logic [27:0]  hi = '0;
    int           cyc = 0;
    int           checks = 0;
    int           fails = 0;

    typedef struct {
        logic [3:0]  din;
        logic [27:0] hi;
        int          polls;
        logic [3:0]  st;
        logic [3:0]  rm;
        logic [3:0]  fm;
        int          pulses;
    } vec_t;

    vec_t tbl[11];

    pio_poll_master #(.POLL_DIV(PD), .DATA_WIDTH(W), .STABLE_COUNT(SC)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_readdata(avm_readdata),
        .state_out(state_out),
        .rise_mask(rise_mask),
        .fall_mask(fall_mask),
        .change_pulse(change_pulse),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (avm_read) avm_readdata <= (avm_address == 2'd0) ? {hi, in_port} : 32'h0;
        cyc <= reset ? 0 : cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic align4();
        for (int k = 0; k < 8 && (cyc % PD) != 4; k++) @(negedge clk);
    endtask

    initial begin
        int np, nr, nb, e0, f0;
        tbl[0]  = '{4'b0000, 28'h0,       1, 4'b0101, 4'b0101, 4'b0000, 0};
        tbl[1]  = '{4'b0101, 28'h0,       3, 4'b0101, 4'b0101, 4'b0000, 0};
        tbl[2]  = '{4'b0100, 28'h0,       3, 4'b0100, 4'b0000, 4'b0001, 1};
        tbl[3]  = '{4'b0000, 28'hFFFFFFF, 3, 4'b0000, 4'b0000, 4'b0100, 1};
        tbl[4]  = '{4'b0000, 28'hFFFFFFF, 3, 4'b0000, 4'b0000, 4'b0100, 0};
        tbl[5]  = '{4'b1010, 28'h0,       2, 4'b0000, 4'b0000, 4'b0100, 0};
        tbl[6]  = '{4'b1010, 28'h0,       1, 4'b1010, 4'b1010, 4'b0000, 1};
        tbl[7]  = '{4'b1010, 28'h0,       3, 4'b1010, 4'b1010, 4'b0000, 0};
        tbl[8]  = '{4'b0110, 28'h0,       3, 4'b0110, 4'b0100, 4'b1000, 1};
        tbl[9]  = '{4'b1111, 28'h0,       1, 4'b0110, 4'b0100, 4'b1000, 0};
        tbl[10] = '{4'b0110, 28'h0,       1, 4'b0110, 4'b0100, 4'b1000, 0};

        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rst_read", avm_read, 0);
            chk("rst_busy", busy, 0);
            chk("rst_state", state_out, 0);
            chk("rst_masks", {rise_mask, fall_mask}, 0);
            chk("rst_pulse", change_pulse, 0);
        end
        reset = 1'b0;
        chk("cycle0", cyc, 0);

        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            chk("sched_read", avm_read, cyc >= 8 && cyc % PD == 0);
            chk("sched_busy", busy, cyc >= 8 && cyc % PD <= 2);
            chk("sched_addr", avm_address, 0);
            chk("sched_pulse", change_pulse, cyc == 27);
            if (cyc == 26) chk("pre_commit_state", state_out, 4'b0000);
            if (cyc == 27) begin
                chk("first_state", state_out, 4'b0101);
                chk("first_rise", rise_mask, 4'b0101);
                chk("first_fall", fall_mask, 4'b0000);
            end
        end

        align4();
        for (int i = 0; i < 11; i++) begin
            in_port = tbl[i].din;
            hi = tbl[i].hi;
            np = 0;
            for (int k = 0; k < tbl[i].polls * PD; k++) begin
                @(negedge clk);
                if (change_pulse) np++;
            end
            chk($sformatf("row%0d_state", i), state_out, tbl[i].st);
            chk($sformatf("row%0d_rise", i), rise_mask, tbl[i].rm);
            chk($sformatf("row%0d_fall", i), fall_mask, tbl[i].fm);
            chk($sformatf("row%0d_pulses", i), np, tbl[i].pulses);
        end
        hi = '0;

        enable = 1'b0;
        nr = 0;
        nb = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (avm_read) nr++;
            if (busy) nb++;
        end
        chk("dis_reads", nr, 0);
        chk("dis_busy", nb, 0);
        enable = 1'b1;
        e0 = cyc;
        nr = 0;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            if (avm_read) nr++;
        end
        chk("en_early_reads", nr, 0);
        @(negedge clk);
        chk("en_first_read", avm_read, 1);
        chk("en_first_cycle", cyc, e0 + 8);

        enable = 1'b0;
        @(negedge clk);
        chk("midfall_capture_busy", busy, 1);
        @(negedge clk);
        chk("midfall_eval_busy", busy, 1);
        @(negedge clk);
        chk("midfall_idle", busy, 0);
        nr = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (avm_read) nr++;
        end
        chk("midfall_reads", nr, 0);

        enable = 1'b1;
        in_port = 4'b1111;
        f0 = cyc;
        nr = 0;
        np = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (avm_read) nr++;
            if (change_pulse) np++;
        end
        chk("prerst_reads", nr, 3);
        chk("prerst_cycle", cyc, f0 + 25);
        chk("prerst_capture", busy, 1);
        chk("prerst_pulses", np, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_read", avm_read, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_state", state_out, 0);
        chk("midrst_masks", {rise_mask, fall_mask}, 0);
        chk("midrst_pulse", change_pulse, 0);
        reset = 1'b0;
        np = 0;
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk);
            if (k < 27 && change_pulse) np++;
            if (k == 26) chk("postrst_hold", state_out, 4'b0000);
        end
        chk("postrst_early_pulses", np, 0);
        chk("postrst_cycle", cyc, 27);
        chk("postrst_pulse", change_pulse, 1);
        chk("postrst_state", state_out, 4'b1111);
        chk("postrst_rise", rise_mask, 4'b1111);
        chk("postrst_fall", fall_mask, 4'b0000);
        @(negedge clk);
        chk("postrst_pulse_end", change_pulse, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
